// File: rtl/scan_frame_receiver.sv
// Processor-side receiver for the scanner serial transfer port: commands a scan, deserialises
// FRAME_BYTES LSB-first bytes into a host-readable frame memory. Optional SCAN_RX_CHECKSUM_EN.
module scan_frame_receiver #(
    parameter int FRAME_BYTES = 10,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       scan_ready,
    output logic [1:0] scan_cmd,
    input  logic       ser_en,
    input  logic       ser_data,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err,
    output logic [3:0] byte_count,
    output logic [7:0] checksum
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_XREQ     = 3'd3,
        ST_XFER     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [4:0] LAST_BYTE = 5'(FRAME_BYTES - 1);

    state_t      state_q, state_d;
    logic [1:0]  scan_cmd_q, scan_cmd_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        timeout_err_q, timeout_err_d;
    logic [4:0]  byte_count_q, byte_count_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rd_data_q;
    logic        mem_we_s;
    logic [7:0]  byte_s;
    logic [7:0]  mem_q [0:15];
`ifdef SCAN_RX_CHECKSUM_EN
    logic [7:0]  checksum_q, checksum_d;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction
`endif

    // Next-state, counters, memory write strobe and registered-output precompute
    always_comb begin
        state_d       = state_q;
        timeout_err_d = timeout_err_q;
        byte_count_d  = byte_count_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_d         = tmo_q;
        shift_d       = shift_q;
        mem_we_s      = 1'b0;
        byte_s        = shift_q;
        byte_s[bit_cnt_q] = ser_data;
`ifdef SCAN_RX_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_REQ;
                    byte_count_d  = 5'd0;
                    timeout_err_d = 1'b0;
                    bit_cnt_d     = 3'd0;
                    shift_d       = 8'h00;
                    tmo_d         = 8'd0;
`ifdef SCAN_RX_CHECKSUM_EN
                    checksum_d    = 8'h00;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT_RDY;
                tmo_d   = 8'd0;
            end
            ST_WAIT_RDY: begin
                if (scan_ready) begin
                    state_d = ST_XREQ;
                    tmo_d   = 8'd0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                    tmo_d         = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            // XREQ and XFER share the bit path; the first qualified bit is what leaves XREQ
            ST_XREQ, ST_XFER: begin
                if (ser_en) begin
                    tmo_d   = 8'd0;
                    state_d = ST_XFER;
                    if (bit_cnt_q == 3'd7) begin
                        mem_we_s     = 1'b1;
                        byte_count_d = byte_count_q + 5'd1;
                        bit_cnt_d    = 3'd0;
                        shift_d      = 8'h00;
`ifdef SCAN_RX_CHECKSUM_EN
                        checksum_d   = csum_update(checksum_q, byte_s);
`endif
                        if (byte_count_q == LAST_BYTE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_XFER;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = byte_s;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                    tmo_d         = 8'd0;
                    bit_cnt_d     = 3'd0;
                    shift_d       = 8'h00;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_REQ:  scan_cmd_d = 2'b01;
            ST_XREQ: scan_cmd_d = 2'b10;
            default: scan_cmd_d = 2'b00;
        endcase
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_DONE);
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            scan_cmd_q    <= 2'b00;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            byte_count_q  <= 5'd0;
            bit_cnt_q     <= 3'd0;
            tmo_q         <= 8'd0;
            shift_q       <= 8'h00;
        end else begin
            state_q       <= state_d;
            scan_cmd_q    <= scan_cmd_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            byte_count_q  <= byte_count_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_q         <= tmo_d;
            shift_q       <= shift_d;
        end
    end

`ifdef SCAN_RX_CHECKSUM_EN
    // Running XOR of stored bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end
    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    // Frame memory write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[byte_count_q[3:0]] <= byte_s;
        end
    end

    // Registered host read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign scan_cmd    = scan_cmd_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;
    assign byte_count  = byte_count_q[3:0];
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_scan_frame_receiver.sv
// Directed bench for scan_frame_receiver: table of full-frame transactions plus hand-written
// reset, timeout, stall and mid-frame reset sequences.
module tb_scan_frame_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       scan_ready = 1'b0;
    logic [1:0] scan_cmd;
    logic       ser_en = 1'b0;
    logic       ser_data = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;
    logic [3:0] byte_count;
    logic [7:0] checksum;

    int checks   = 0;
    int failures = 0;
    int mon_cmd1 = 0;
    int mon_done = 0;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        int         ready_dly;
        int         extra_bits;
        int         gap;
        logic [7:0] exp_csum;
    } frame_vec_t;

    frame_vec_t vecs [4];

    scan_frame_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .scan_ready (scan_ready),
        .scan_cmd   (scan_cmd),
        .ser_en     (ser_en),
        .ser_data   (ser_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .frame_done (frame_done),
        .timeout_err(timeout_err),
        .byte_count (byte_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Counts start-scan command cycles and frame_done pulses
    always @(negedge clk) begin
        if (scan_cmd == 2'b01) mon_cmd1++;
        if (frame_done === 1'b1) mon_done++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ser_en   = 1'b1;
        ser_data = b;
        tick();
        ser_en   = 1'b0;
        ser_data = 1'b0;
    endtask

    function automatic logic [7:0] csum_exp(input logic [7:0] v);
`ifdef SCAN_RX_CHECKSUM_EN
        return v;
`else
        return 8'h00 & v;
`endif
    endfunction

    task automatic start_to_xreq(input int ready_dly);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("req_cmd", 32'(scan_cmd), 32'd1);
        check("req_busy", 32'(busy), 32'd1);
        check("start_clears_err", 32'(timeout_err), 32'd0);
        repeat (ready_dly) tick();
        scan_ready = 1'b1;
        n = 0;
        while (scan_cmd !== 2'b10 && n < 20) begin
            tick();
            n++;
        end
        check("xreq_reached", 32'(scan_cmd), 32'd2);
        scan_ready = 1'b0;
        tick();
        check("xreq_hold", 32'(scan_cmd), 32'd2);
    endtask

    task automatic read_check(input int addr, input logic [7:0] exp);
        rd_addr = 4'(addr);
        tick();
        check("rd_data", 32'(rd_data), 32'(exp));
    endtask

    task automatic run_frame(input frame_vec_t v);
        int done0, cmd0;
        logic [7:0] b;
        done0 = mon_done;
        cmd0  = mon_cmd1;
        start_to_xreq(v.ready_dly);
        for (int k = 0; k < 10; k++) begin
            b = 8'(v.base + 8'(k) * v.step);
            for (int i = 0; i < 8; i++) begin
                send_bit(b[i]);
                if (k == 0 && i == 0) check("cmd_after_first_bit", 32'(scan_cmd), 32'd0);
                if (k == 4 && i == 3) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
                if (!(k == 9 && i == 7)) repeat (v.gap) tick();
            end
        end
        check("done_latency", 32'(frame_done), 32'd1);
        check("frame_byte_count", 32'(byte_count), 32'd10);
        check("frame_checksum", 32'(checksum), 32'(csum_exp(v.exp_csum)));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_single_cycle", 32'(frame_done), 32'd0);
        check("start_with_done_ignored", 32'(busy), 32'd0);
        for (int i = 0; i < v.extra_bits; i++) send_bit(1'(i % 2));
        repeat (3) tick();
        check("done_pulse_count", 32'(mon_done - done0), 32'd1);
        check("cmd01_cycles", 32'(mon_cmd1 - cmd0), 32'd1);
        check("count_after_trailing", 32'(byte_count), 32'd10);
        check("idle_busy", 32'(busy), 32'd0);
        check("no_timeout", 32'(timeout_err), 32'd0);
        for (int k = 0; k < 10; k++) read_check(k, 8'(v.base + 8'(k) * v.step));
    endtask

    initial begin
        int n;
        int done0;
        logic [7:0] b;

        vecs[0] = '{8'h00, 8'h01, 8, 0, 0, 8'h01};
        vecs[1] = '{8'h00, 8'h01, 8, 7, 0, 8'h01};
        vecs[2] = '{8'hFB, 8'h01, 3, 0, 1, 8'hFF};
        vecs[3] = '{8'h00, 8'h03, 0, 2, 2, 8'h0B};

        // reset state
        tick();
        tick();
        check("rst_scan_cmd", 32'(scan_cmd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        tick();

        // scan_ready never comes: REQ plus 255 WAIT_RDY cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            tick();
            n++;
        end
        check("wait_timeout_cycles", 32'(n), 32'd256);
        check("wait_timeout_err", 32'(timeout_err), 32'd1);
        check("wait_timeout_cmd", 32'(scan_cmd), 32'd0);
        tick();

        // stall after 43 bits: 5 bytes kept, partial byte dropped
        done0 = mon_done;
        start_to_xreq(8);
        for (int j = 0; j < 43; j++) begin
            b = 8'(8'h30 + 8'(j / 8));
            send_bit(b[j % 8]);
        end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("stall_timeout_cycles", 32'(n), 32'd255);
        check("stall_timeout_err", 32'(timeout_err), 32'd1);
        check("stall_byte_count", 32'(byte_count), 32'd5);
        check("stall_checksum", 32'(checksum), 32'(csum_exp(8'h34)));
        check("stall_no_done", 32'(mon_done - done0), 32'd0);
        for (int k = 0; k < 5; k++) read_check(k, 8'(8'h30 + 8'(k)));

        // synchronous reset in the middle of a transfer
        done0 = mon_done;
        start_to_xreq(0);
        for (int j = 0; j < 20; j++) begin
            b = 8'(8'h40 + 8'(j / 8));
            send_bit(b[j % 8]);
        end
        rst      = 1'b1;
        ser_en   = 1'b1;
        ser_data = 1'b1;
        tick();
        rst      = 1'b0;
        ser_en   = 1'b0;
        ser_data = 1'b0;
        check("midrst_scan_cmd", 32'(scan_cmd), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_byte_count", 32'(byte_count), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        repeat (3) tick();
        check("midrst_no_done", 32'(mon_done - done0), 32'd0);

        // full frames, first one right after the mid-frame reset
        for (int r = 0; r < 4; r++) begin
            run_frame(vecs[r]);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
